// File: rtl/pc_pkg.sv
// pc_pkg: next-PC select codes and a constant log2 helper shared by the PC sequencer
package pc_pkg;
  localparam logic [2:0] SEL_HOLD = 3'd0;
  localparam logic [2:0] SEL_SEQ  = 3'd1;
  localparam logic [2:0] SEL_BR   = 3'd2;
  localparam logic [2:0] SEL_J    = 3'd3;
  localparam logic [2:0] SEL_JR   = 3'd4;
  localparam logic [2:0] SEL_CALL = 3'd5;
  localparam logic [2:0] SEL_RET  = 3'd6;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-control bundle between the front end and the PC sequencer
interface pc_sequencer_if #(parameter int ADDR_WIDTH = 32) ();
  logic                  Stall;
  logic                  BranchTaken;
  logic [ADDR_WIDTH-1:0] BranchOffset;
  logic                  Jump;
  logic [ADDR_WIDTH-1:0] JumpTarget;
  logic                  JumpReg;
  logic [ADDR_WIDTH-1:0] RegTarget;
  logic                  Call;
  logic                  Return;
  logic [ADDR_WIDTH-1:0] PCResult;
  logic [ADDR_WIDTH-1:0] PCPlusInc;
  logic                  RasEmpty;
  logic                  RasFull;
  logic                  MisalignFault;
  modport master (
    output Stall, BranchTaken, BranchOffset, Jump, JumpTarget, JumpReg, RegTarget, Call, Return,
    input  PCResult, PCPlusInc, RasEmpty, RasFull, MisalignFault
  );
  modport slave (
    input  Stall, BranchTaken, BranchOffset, Jump, JumpTarget, JumpReg, RegTarget, Call, Return,
    output PCResult, PCPlusInc, RasEmpty, RasFull, MisalignFault
  );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack that overwrites its oldest entry when full
module pc_ras
  import pc_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] top,
  output logic                  empty,
  output logic                  full
);
  localparam int PW = clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]         ptr;
  logic [CW-1:0]         cnt, cnt_next;
  assign top = mem[ptr - PW'(1)];
  // count saturates on push-when-full because the oldest slot is simply reused
  always_comb cnt_next = push ? (full ? cnt : cnt + CW'(1)) : (pop && !empty) ? cnt - CW'(1) : cnt;
  // storage is not reset; entries are only visible once the count covers them
  always_ff @(posedge Clk) if (Reset && push) mem[ptr] <= push_data;
  // pointer, count and registered occupancy flags
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ptr   <= '0;
      cnt   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      ptr   <= push ? ptr + PW'(1) : (pop && !empty) ? ptr - PW'(1) : ptr;
      cnt   <= cnt_next;
      empty <= cnt_next == '0;
      full  <= cnt_next == CW'(RAS_DEPTH);
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with prioritised next-PC selection, RAS and misalignment fault
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    INC          = 4,
  parameter int                    RAS_DEPTH    = 4
) (
  input logic          Clk,
  input logic          Reset,
  pc_sequencer_if.slave bus
);
  localparam int                    LSB  = clog2(INC);
  localparam logic [ADDR_WIDTH-1:0] MASK = ADDR_WIDTH'(INC - 1);
  logic [2:0]            sel;
  logic [ADDR_WIDTH-1:0] pc, pc_inc, next_pc, top;
  logic                  misal, push, pop, empty, full, fault;
  assign pc_inc = pc + ADDR_WIDTH'(INC);
  // fixed priority: stall, return, call, jump-register, jump, branch, sequential
  always_comb sel = bus.Stall ? SEL_HOLD : bus.Return ? SEL_RET : bus.Call ? SEL_CALL :
                    bus.JumpReg ? SEL_JR : bus.Jump ? SEL_J : bus.BranchTaken ? SEL_BR : SEL_SEQ;
  // only the selected source reaches next_pc, so idle target inputs may float
  always_comb next_pc = sel == SEL_RET ? (empty ? bus.RegTarget : top) :
                        (sel == SEL_CALL || sel == SEL_J) ? bus.JumpTarget :
                        sel == SEL_JR ? bus.RegTarget :
                        sel == SEL_BR ? pc_inc + (bus.BranchOffset << LSB) :
                        sel == SEL_SEQ ? pc_inc : pc;
  assign misal = sel != SEL_HOLD && sel != SEL_SEQ && |(next_pc & MASK);
  assign push  = sel == SEL_CALL && !misal;
  assign pop   = sel == SEL_RET && !empty && !misal;
  pc_ras #(.ADDR_WIDTH(ADDR_WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .Clk(Clk), .Reset(Reset), .push(push), .pop(pop), .push_data(pc_inc),
    .top(top), .empty(empty), .full(full)
  );
  // a rejected target holds the PC and raises a one-cycle fault
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc    <= RESET_VECTOR;
      fault <= 1'b0;
    end else begin
      pc    <= (sel != SEL_HOLD && !misal) ? next_pc : pc;
      fault <= misal;
    end
  end
  assign bus.PCResult      = pc;
  assign bus.PCPlusInc     = pc_inc;
  assign bus.RasEmpty      = empty;
  assign bus.RasFull       = full;
  assign bus.MisalignFault = fault;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomised checks of pc_sequencer against a queue-based model
module tb_pc_sequencer;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic reset16 = 1'b0;
  int passed = 0;
  int total = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  always #5 Clk = ~Clk;

  pc_sequencer_if #(.ADDR_WIDTH(32)) b32 ();
  pc_sequencer_if #(.ADDR_WIDTH(16)) b16 ();

  pc_sequencer #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .INC(4), .RAS_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .bus(b32.slave));
  pc_sequencer #(.ADDR_WIDTH(16), .RESET_VECTOR(16'hFFF8), .INC(4), .RAS_DEPTH(4)) dut16 (
    .Clk(Clk), .Reset(reset16), .bus(b16.slave));

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    b32.Stall = 0; b32.BranchTaken = 0; b32.BranchOffset = '0; b32.Jump = 0; b32.JumpTarget = '0;
    b32.JumpReg = 0; b32.RegTarget = '0; b32.Call = 0; b32.Return = 0;
  endtask

  task automatic test_reset();
    idle();
    Reset = 0; b32.Jump = 1; b32.JumpTarget = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (b32.PCResult !== 32'h0 || b32.RasEmpty !== 1'b1 || b32.RasFull !== 1'b0 || b32.MisalignFault !== 1'b0)
        $display("FAIL reset_hold cyc%0d pc=%h empty=%b full=%b fault=%b want pc=0 empty=1 full=0 fault=0",
                 i, b32.PCResult, b32.RasEmpty, b32.RasFull, b32.MisalignFault);
      else passed++;
    end
    Reset = 1; idle();
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (b32.PCResult !== 32'(4 * (i + 1))) $display("FAIL release_seq%0d got %h want %h", i, b32.PCResult, 32'(4 * (i + 1)));
      else passed++;
    end
  endtask

  task automatic test_branch_stall();
    step();
    total++;
    if (b32.PCResult !== 32'h10) $display("FAIL pre_branch got %h want 00000010", b32.PCResult); else passed++;
    b32.BranchTaken = 1; b32.BranchOffset = 32'hFFFF_FFFE; b32.Stall = 1;
    total++;
    if (b32.PCPlusInc !== 32'h14) $display("FAIL pcplusinc got %h want 00000014", b32.PCPlusInc); else passed++;
    step();
    total++;
    if (b32.PCResult !== 32'h10 || b32.MisalignFault !== 1'b0)
      $display("FAIL stall_hold pc=%h fault=%b want 00000010 0", b32.PCResult, b32.MisalignFault);
    else passed++;
    b32.Stall = 0;
    step();
    total++;
    if (b32.PCResult !== 32'hC) $display("FAIL branch_back got %h want 0000000c", b32.PCResult); else passed++;
    idle();
    step();
    total++;
    if (b32.PCResult !== 32'h10) $display("FAIL post_branch got %h want 00000010", b32.PCResult); else passed++;
  endtask

  task automatic test_ras_overflow();
    logic [31:0] tg [5];
    logic [31:0] rt [5];
    tg = '{32'h200, 32'h300, 32'h400, 32'h500, 32'h600};
    rt = '{32'h504, 32'h404, 32'h304, 32'h204, 32'h40};
    for (int i = 0; i < 5; i++) begin
      b32.Call = 1; b32.JumpTarget = tg[i];
      step();
      total++;
      if (b32.PCResult !== tg[i] || b32.RasFull !== (i >= 3) || b32.RasEmpty !== 1'b0)
        $display("FAIL call%0d pc=%h full=%b empty=%b want pc=%h full=%b empty=0",
                 i, b32.PCResult, b32.RasFull, b32.RasEmpty, tg[i], i >= 3);
      else passed++;
    end
    b32.Call = 0; b32.Return = 1; b32.RegTarget = 32'h40;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (b32.PCResult !== rt[i] || b32.RasEmpty !== (i >= 3) || b32.RasFull !== 1'b0)
        $display("FAIL ret%0d pc=%h empty=%b full=%b want pc=%h empty=%b full=0",
                 i, b32.PCResult, b32.RasEmpty, b32.RasFull, rt[i], i >= 3);
      else passed++;
    end
    idle();
  endtask

  task automatic test_call_return_same();
    b32.Jump = 1; b32.JumpTarget = 32'h80;
    step();
    total++;
    if (b32.PCResult !== 32'h80) $display("FAIL jump80 got %h want 00000080", b32.PCResult); else passed++;
    b32.Jump = 0; b32.Call = 1; b32.JumpTarget = 32'h100;
    step();
    total++;
    if (b32.PCResult !== 32'h100 || b32.RasEmpty !== 1'b0)
      $display("FAIL call100 pc=%h empty=%b want 00000100 0", b32.PCResult, b32.RasEmpty);
    else passed++;
    b32.Return = 1; b32.JumpTarget = 32'h300;
    step();
    total++;
    if (b32.PCResult !== 32'h84 || b32.RasEmpty !== 1'b1)
      $display("FAIL call_ret_same pc=%h empty=%b want 00000084 1", b32.PCResult, b32.RasEmpty);
    else passed++;
    b32.Call = 0; b32.RegTarget = 32'h44;
    step();
    total++;
    if (b32.PCResult !== 32'h44) $display("FAIL no_push_check got %h want 00000044", b32.PCResult); else passed++;
    idle();
  endtask

  task automatic test_misalign();
    b32.Call = 1; b32.JumpTarget = 32'h20;
    step();
    total++;
    if (b32.PCResult !== 32'h20 || b32.RasEmpty !== 1'b0)
      $display("FAIL call20 pc=%h empty=%b want 00000020 0", b32.PCResult, b32.RasEmpty);
    else passed++;
    b32.Call = 0; b32.JumpReg = 1; b32.RegTarget = 32'h102;
    step();
    total++;
    if (b32.PCResult !== 32'h20 || b32.MisalignFault !== 1'b1 || b32.RasEmpty !== 1'b0)
      $display("FAIL jr_misalign pc=%h fault=%b empty=%b want 00000020 1 0", b32.PCResult, b32.MisalignFault, b32.RasEmpty);
    else passed++;
    b32.JumpReg = 0;
    step();
    total++;
    if (b32.PCResult !== 32'h24 || b32.MisalignFault !== 1'b0)
      $display("FAIL after_fault pc=%h fault=%b want 00000024 0", b32.PCResult, b32.MisalignFault);
    else passed++;
    b32.Call = 1; b32.JumpTarget = 32'h201;
    step();
    total++;
    if (b32.PCResult !== 32'h24 || b32.MisalignFault !== 1'b1)
      $display("FAIL call_misalign pc=%h fault=%b want 00000024 1", b32.PCResult, b32.MisalignFault);
    else passed++;
    b32.Call = 0; b32.Return = 1;
    step();
    total++;
    if (b32.PCResult !== 32'h48 || b32.MisalignFault !== 1'b0 || b32.RasEmpty !== 1'b1)
      $display("FAIL ret_after_bad_call pc=%h fault=%b empty=%b want 00000048 0 1", b32.PCResult, b32.MisalignFault, b32.RasEmpty);
    else passed++;
    b32.RegTarget = 32'h43;
    step();
    total++;
    if (b32.PCResult !== 32'h48 || b32.MisalignFault !== 1'b1)
      $display("FAIL ret_fallback_misalign pc=%h fault=%b want 00000048 1", b32.PCResult, b32.MisalignFault);
    else passed++;
    idle();
    step();
    total++;
    if (b32.PCResult !== 32'h4C || b32.MisalignFault !== 1'b0)
      $display("FAIL fault_one_cycle pc=%h fault=%b want 0000004c 0", b32.PCResult, b32.MisalignFault);
    else passed++;
  endtask

  task automatic test_wrap16();
    reset16 = 0;
    step();
    reset16 = 1;
    total++;
    if (b16.PCResult !== 16'hFFF8) $display("FAIL w16_reset got %h want fff8", b16.PCResult); else passed++;
    step();
    total++;
    if (b16.PCResult !== 16'hFFFC || b16.PCPlusInc !== 16'h0000)
      $display("FAIL w16_top pc=%h inc=%h want fffc 0000", b16.PCResult, b16.PCPlusInc);
    else passed++;
    step();
    total++;
    if (b16.PCResult !== 16'h0000 || b16.MisalignFault !== 1'b0)
      $display("FAIL w16_wrap pc=%h fault=%b want 0000 0", b16.PCResult, b16.MisalignFault);
    else passed++;
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(7) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic test_random();
    logic [31:0] t;
    bit seq, flt;
    idle();
    Reset = 0;
    step();
    Reset = 1;
    m_pc = 32'h0;
    m_ras.delete();
    for (int n = 0; n < 400; n++) begin
      b32.Stall = $urandom_range(7) == 0;
      b32.Return = $urandom_range(5) == 0;
      b32.Call = $urandom_range(4) == 0;
      b32.JumpReg = $urandom_range(7) == 0;
      b32.Jump = $urandom_range(7) == 0;
      b32.BranchTaken = $urandom_range(3) == 0;
      b32.JumpTarget = (b32.Jump || b32.Call) ? rnd_tgt() : 'x;
      b32.RegTarget = (b32.JumpReg || b32.Return) ? rnd_tgt() : 'x;
      b32.BranchOffset = !b32.BranchTaken ? 'x : ($urandom_range(3) == 0) ? 32'($urandom) : 32'($urandom_range(64)) - 32'd32;
      #1;
      total++;
      if (b32.PCPlusInc !== m_pc + 32'd4) $display("FAIL rnd_inc n=%0d got %h want %h", n, b32.PCPlusInc, m_pc + 32'd4);
      else passed++;
      flt = 0;
      if (!b32.Stall) begin
        seq = 0;
        if (b32.Return) t = (m_ras.size() > 0) ? m_ras[$] : b32.RegTarget;
        else if (b32.Call) t = b32.JumpTarget;
        else if (b32.JumpReg) t = b32.RegTarget;
        else if (b32.Jump) t = b32.JumpTarget;
        else if (b32.BranchTaken) t = m_pc + 32'd4 + b32.BranchOffset * 32'd4;
        else begin t = m_pc + 32'd4; seq = 1; end
        flt = !seq && (t[1:0] != 2'b00);
        if (!flt) begin
          if (b32.Return) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
          end else if (b32.Call) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
          end
          m_pc = t;
        end
      end
      step();
      total++;
      if (b32.PCResult !== m_pc) $display("FAIL rnd_pc n=%0d got %h want %h", n, b32.PCResult, m_pc);
      else passed++;
      total++;
      if (b32.MisalignFault !== flt || b32.RasEmpty !== (m_ras.size() == 0) || b32.RasFull !== (m_ras.size() == 4))
        $display("FAIL rnd_flags n=%0d fault=%b empty=%b full=%b want %b %b %b", n, b32.MisalignFault,
                 b32.RasEmpty, b32.RasFull, flt, m_ras.size() == 0, m_ras.size() == 4);
      else passed++;
    end
    idle();
  endtask

  initial begin
    b16.Stall = 0; b16.BranchTaken = 0; b16.BranchOffset = '0; b16.Jump = 0; b16.JumpTarget = '0;
    b16.JumpReg = 0; b16.RegTarget = '0; b16.Call = 0; b16.Return = 0;
    test_reset();
    test_branch_stall();
    test_ras_overflow();
    test_call_return_same();
    test_misalign();
    test_wrap16();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
